// File: rtl/msix_bram_arbiter.sv
// Two-requester arbiter in front of a single-port BRAM.
// Grants at most one access per cycle with a bounded burst length, registers
// the BRAM port signals, and returns read data to the issuer three cycles after
// the grant.
module msix_bram_arbiter #(
  parameter int DATA      = 32,
  parameter int ADDR      = 10,
  parameter int MAX_BURST = 4
) (
  input  logic            clk,
  input  logic            rst,
  // requester 0
  input  logic            r0_req,
  input  logic            r0_wr,
  input  logic [ADDR-1:0] r0_addr,
  input  logic [DATA-1:0] r0_din,
  output logic            r0_gnt,
  output logic [DATA-1:0] r0_dout,
  output logic            r0_dvalid,
  // requester 1
  input  logic            r1_req,
  input  logic            r1_wr,
  input  logic [ADDR-1:0] r1_addr,
  input  logic [DATA-1:0] r1_din,
  output logic            r1_gnt,
  output logic [DATA-1:0] r1_dout,
  output logic            r1_dvalid,
  // BRAM port
  output logic            m_wr,
  output logic [ADDR-1:0] m_addr,
  output logic [DATA-1:0] m_din,
  input  logic [DATA-1:0] m_dout
);

  localparam int              CW      = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0]   CNT_ONE = CW'(1);

  // Arbitration state: last granted requester and its current burst length.
  logic          owner, owner_nxt;
  logic [CW-1:0] burst_cnt, burst_cnt_nxt;

  logic own_req, oth_req;
  logic grant_owner, grant_other;

  // Read-return pipeline: read flag and requester tag travel with the access.
  logic s1_rd, s1_tag;
  logic s2_rd, s2_tag;

  logic acc_valid;
  logic sel;

  // Arbitration state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (rst) begin
      owner     <= 1'b1;
      burst_cnt <= CNT_MAX;
    end else begin
      owner     <= owner_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  // Next-state logic: keep the owner until its burst expires while the other waits.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    owner_nxt     = owner;
    burst_cnt_nxt = burst_cnt;
    own_req       = owner ? r1_req : r0_req;
    oth_req       = owner ? r0_req : r1_req;
    grant_owner   = !rst && own_req && (!oth_req || (burst_cnt < CNT_MAX));
    grant_other   = !rst && oth_req && !grant_owner;
    if (grant_owner) begin
      burst_cnt_nxt = (burst_cnt == CNT_MAX) ? burst_cnt : burst_cnt + CNT_ONE;
    end else if (grant_other) begin
      owner_nxt     = !owner;
      burst_cnt_nxt = CNT_ONE;
    end else begin
      // An idle cycle ends the burst so the next contested cycle switches owner.
      burst_cnt_nxt = CNT_MAX;
    end
  end

  // Grant outputs decoded from owner-relative grant decisions.
  always_comb begin
    r0_gnt    = (grant_owner && !owner) || (grant_other && owner);
    r1_gnt    = (grant_owner && owner)  || (grant_other && !owner);
    acc_valid = r0_gnt || r1_gnt;
    sel       = r1_gnt;
  end

  // BRAM port registers and read-return pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      m_wr      <= 1'b0;
      m_addr    <= '0;
      m_din     <= '0;
      s1_rd     <= 1'b0;
      s1_tag    <= 1'b0;
      s2_rd     <= 1'b0;
      s2_tag    <= 1'b0;
      r0_dout   <= '0;
      r0_dvalid <= 1'b0;
      r1_dout   <= '0;
      r1_dvalid <= 1'b0;
    end else begin
      m_wr <= acc_valid && (sel ? r1_wr : r0_wr);
      if (acc_valid) begin
        m_addr <= sel ? r1_addr : r0_addr;
        m_din  <= sel ? r1_din  : r0_din;
      end
      s1_rd  <= acc_valid && !(sel ? r1_wr : r0_wr);
      s1_tag <= sel;
      // Stage 2 is the cycle the BRAM presents data for the stage-1 address.
      s2_rd  <= s1_rd;
      s2_tag <= s1_tag;
      r0_dvalid <= s2_rd && !s2_tag;
      r1_dvalid <= s2_rd && s2_tag;
      if (s2_rd && !s2_tag) r0_dout <= m_dout;
      if (s2_rd && s2_tag)  r1_dout <= m_dout;
    end
  end

endmodule
